timer_ctrl: RTL

//  Timer/scheduler around a loadable up-counter: generates the counter's count-enable from a

---
 rtl/timer_ctrl_pkg.sv | 25 ++
 rtl/timer_presc.sv | 28 ++
 rtl/timer_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer block: register map, CTRL/STAT bit positions, FSM encoding.
// Optional PWM support (CMP register, pwm output) is enabled by defining TIMER_PWM_EN.
package timer_ctrl_pkg;

    localparam logic [2:0] A_CNT   = 3'd0;
    localparam logic [2:0] A_MATCH = 3'd1;
    localparam logic [2:0] A_CTRL  = 3'd2;
    localparam logic [2:0] A_STAT  = 3'd3;
    localparam logic [2:0] A_CMP   = 3'd4;

    localparam int unsigned B_EN      = 0;
    localparam int unsigned B_ONESHOT = 1;
    localparam int unsigned B_IRQEN   = 2;
    localparam int unsigned B_PRESC   = 8;

    localparam int unsigned B_FLAG    = 0;
    localparam int unsigned B_RUNNING = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/timer_presc.sv
// Programmable prescaler: while run is high, counts 0..div and pulses tick on the terminal count.
// clear restarts the division so the first tick after a start is a full period away.
module timer_presc #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               run,
    input  logic [PRESC_W-1:0] div,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = run && (cnt == div);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clear || tick || !run)
            cnt <= '0;
        else
            cnt <= cnt + PRESC_W'(1);
    end

endmodule

// File: rtl/timer_ctrl.sv
// Timer/scheduler: bus registers, prescaled up-counter with match flag/IRQ and a run FSM.
// Define TIMER_PWM_EN to add the CMP register (addr 4) and a registered pwm output.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             irq,
    output logic             pwm
);

    state_t state, next_state;

    logic [WIDTH-1:0]   cnt_q;
    logic [WIDTH-1:0]   match_q;
    logic               ctrl_en;
    logic               ctrl_oneshot;
    logic               ctrl_irqen;
    logic [PRESC_W-1:0] ctrl_presc;
    logic               flag_q;
    logic               running;
    logic               tick;

    logic wr, cnt_wr, match_wr, ctrl_wr, stat_wr;
    logic start, stop, cnt_tick, hit, finish;

    assign wr       = cs && we;
    assign cnt_wr   = wr && (addr == A_CNT);
    assign match_wr = wr && (addr == A_MATCH);
    assign ctrl_wr  = wr && (addr == A_CTRL);
    assign stat_wr  = wr && (addr == A_STAT);

    // A stopping CTRL write suppresses the coincident tick entirely: no count, no flag, no DONE.
    assign start    = ctrl_wr &&  wdata[B_EN] && (state != S_RUN);
    assign stop     = ctrl_wr && !wdata[B_EN] && (state == S_RUN);
    assign cnt_tick = tick && !stop;
    assign hit      = cnt_tick && (cnt_q == match_q);
    assign finish   = hit && ctrl_oneshot && !ctrl_wr;

    timer_presc #(.PRESC_W(PRESC_W)) u_presc (
        .clk   (clk),
        .reset (reset),
        .clear (start),
        .run   (running),
        .div   (ctrl_presc),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: defaulting next_state first keeps this block free of inferred latches.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: if (start) next_state = S_RUN;
            S_RUN: begin
                if (stop)
                    next_state = S_IDLE;
                else if (finish)
                    next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        running = (state == S_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            match_q <= '0;
        end else begin
            if (cnt_wr)
                cnt_q <= wdata;
            else if (cnt_tick)
                cnt_q <= (cnt_q == match_q) ? '0 : cnt_q + WIDTH'(1);
            if (match_wr)
                match_q <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en      <= 1'b0;
            ctrl_oneshot <= 1'b0;
            ctrl_irqen   <= 1'b0;
            ctrl_presc   <= '0;
        end else if (ctrl_wr) begin
            ctrl_en      <= wdata[B_EN];
            ctrl_oneshot <= wdata[B_ONESHOT];
            ctrl_irqen   <= wdata[B_IRQEN];
            ctrl_presc   <= wdata[B_PRESC +: PRESC_W];
        end else if (finish) begin
            ctrl_en      <= 1'b0;
        end
    end

    // Set wins over the W1C clear so a match landing on the clearing write is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            flag_q <= 1'b0;
        else if (hit)
            flag_q <= 1'b1;
        else if (stat_wr && wdata[B_FLAG])
            flag_q <= 1'b0;
    end

    assign irq = flag_q && ctrl_irqen;

`ifdef TIMER_PWM_EN
    logic [WIDTH-1:0] cmp_q;
    logic             pwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            if (wr && (addr == A_CMP))
                cmp_q <= wdata;
            pwm_q <= running && (cnt_q < cmp_q);
        end
    end

    assign pwm = pwm_q;
`else
    assign pwm = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (cs) begin
            case (addr)
                A_CNT:   rdata = cnt_q;
                A_MATCH: rdata = match_q;
                A_CTRL: begin
                    rdata[B_EN]                = ctrl_en;
                    rdata[B_ONESHOT]           = ctrl_oneshot;
                    rdata[B_IRQEN]             = ctrl_irqen;
                    rdata[B_PRESC +: PRESC_W]  = ctrl_presc;
                end
                A_STAT: begin
                    rdata[B_FLAG]    = flag_q;
                    rdata[B_RUNNING] = running;
                end
`ifdef TIMER_PWM_EN
                A_CMP:   rdata = cmp_q;
`else
                A_CMP:   rdata = '0;
`endif
                default: rdata = '0;
            endcase
        end
    end

endmodule
